id_hazard_ctrl: RTL
===================

Name: id_hazard_ctrl

Overview:
- Parametrised successor to the ID-stage conflict logic.
- Tracks in-flight destination registers in a DEPTH-entry scoreboard shift register.
- Produces per-operand forwarding selects, load-use stalls with configurable load latency, and a syscall drain FSM; sits in ID and drives the IF/ID hold and ID/EX bubble.
- Optional per-event performance counters.

Parameters:
- RA_W, 5, register address width; address 0 is never a hazard source.
- DEPTH, 3, number of tracked downstream stages (entry 0 = EX, DEPTH-1 = WB); minimum 2.
- LOAD_LAT, 1, a load in entry i < LOAD_LAT cannot forward; 1 ≤ LOAD_LAT < DEPTH.
- SYS_A, 2, first syscall source register.
- SYS_B, 4, second syscall source register.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_ra  in  RA_W  operand A register.
- id_rb  in  RA_W  operand B register.
- id_use_a  in  1  instruction reads A.
- id_use_b  in  1  instruction reads B.
- id_des  in  RA_W  destination register; 0 = none.
- id_load  in  1  instruction is a load.
- id_sys  in  1  instruction is a syscall; reads SYS_A/SYS_B.
- flush  in  1  taken branch/jump resolved; kill the ID instruction this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  clear ID/EX.
- fwd_a  out  clog2(DEPTH+1)  0 = regfile, k = entry k-1.
- fwd_b  out  clog2(DEPTH+1)  as fwd_a.
- lu_cnt  out  CNT_W  load-use stall cycles.
- sys_cnt  out  CNT_W  syscall drain cycles.
- flush_cnt  out  CNT_W  flushes.

Behaviour:
- Scoreboard entry: {v, des, ld}. Every clock, entries shift 0→1→…; entry DEPTH-1 drops off.
- Entry 0 load: {1, id_des, id_load} when issue = id_valid & !stall & !flush; otherwise all-zero.
- Match(r, i): v_i & des_i==r & r!=0.
- Forward select: the lowest i with Match gives fwd = i+1; no match gives 0. An unused operand gives fwd 0.
- Load-use hazard: for a used operand, the lowest matching entry i has ld_i and i < LOAD_LAT. Stall lasts exactly LOAD_LAT-i cycles; forwarding then comes from entry LOAD_LAT.
- Sys hazard: id_sys & any v_i with des_i ∈ {SYS_A, SYS_B}, i over all entries.
- FSM RUN/SYS_WAIT:
  - RUN → SYS_WAIT when id_valid & sys hazard & !flush.
  - SYS_WAIT → RUN when the sys hazard clears or flush is asserted.
  - stall=1 throughout SYS_WAIT; the syscall issues on the cycle after returning to RUN.
- stall = id_valid & !flush & (load-use | sys hazard); bubble = stall | flush.
- Outputs are combinational from registered state plus ID inputs; no added latency.
- flush has priority over stall in the same cycle: stall=0, bubble=1, nothing issued, FSM → RUN.
- id_valid=0: stall=0, bubble=0, fwd=0, bubble enters entry 0.
- Reset (rst=0 at edge):
  - all entries invalid, FSM=RUN, counters 0.
  - outputs become stall=0, bubble=0, fwd=0.
  - reset mid-stall drops the stall immediately.
- Counters saturate at all-ones.
  - lu_cnt increments per load-use stall cycle.
  - sys_cnt increments per SYS_WAIT cycle.
  - flush_cnt increments per flush cycle.

Optional Feature:
- HAZARD_STATS_EN defined: the three counters are implemented.
- Undefined: counters absent and the outputs are tied to 0; all other behaviour is identical.

Test Plan:
- Issue add $3 ← …; next instruction reads $3 in A → fwd_a=1, stall=0. One cycle later the reader sees fwd_a=2; with DEPTH=3, after 3 cycles fwd_a=0.
- LOAD_LAT=1: lw $5, then the next instruction uses $5 in B → stall=1 and bubble=1 for 1 cycle, then fwd_b=2, lu_cnt=1. With LOAD_LAT=2, the same sequence stalls 2 cycles and lu_cnt=2.
- Two in-flight writers to $7 (entries 0 and 2) → fwd_a=1 (youngest); writes to $0 → fwd always 0, never stall.
- addi $2 then syscall → FSM SYS_WAIT for 3 cycles (DEPTH=3), stall=1, sys_cnt=3, then the syscall issues.
- Load-use stall with flush=1 in the same cycle → stall=0, bubble=1, flush_cnt=1, entry 0 invalid next cycle.
- rst=0 during SYS_WAIT → next cycle stall=0, FSM RUN, counters 0; without HAZARD_STATS_EN, counters read 0 throughout.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage scoreboard: forwarding selects, load-use and syscall drain stalls
// HAZARD_STATS_EN enables the saturating event counters; otherwise they read 0.
module id_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SYS_A    = 2,
  parameter int SYS_B    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [RA_W-1:0]              id_ra,
  input  logic [RA_W-1:0]              id_rb,
  input  logic                         id_use_a,
  input  logic                         id_use_b,
  input  logic [RA_W-1:0]              id_des,
  input  logic                         id_load,
  input  logic                         id_sys,
  input  logic                         flush,
  output logic                         stall,
  output logic                         bubble,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
  output logic [CNT_W-1:0]             lu_cnt,
  output logic [CNT_W-1:0]             sys_cnt,
  output logic [CNT_W-1:0]             flush_cnt
);

  localparam int FWD_W = $clog2(DEPTH+1);

  typedef enum logic {ST_RUN, ST_SYS_WAIT} state_t;

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   sb_v;
  logic [DEPTH-1:0]   sb_ld;
  logic [RA_W-1:0]    sb_des [DEPTH];

  logic [FWD_W-1:0]   sel_a, sel_b;
  logic               ld_a, ld_b;
  logic               sys_src_busy;
  logic               sys_haz;
  logic               lu_haz;
  logic               issue;

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    sys_src_busy = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (sb_v[i] && sb_des[i] == id_ra && id_ra != '0) begin
        sel_a = FWD_W'(i+1);
        ld_a  = sb_ld[i] && (i < LOAD_LAT);
      end
      if (sb_v[i] && sb_des[i] == id_rb && id_rb != '0) begin
        sel_b = FWD_W'(i+1);
        ld_b  = sb_ld[i] && (i < LOAD_LAT);
      end
      if (sb_v[i] && (sb_des[i] == RA_W'(SYS_A) || sb_des[i] == RA_W'(SYS_B)))
        sys_src_busy = 1'b1;
    end
  end

  always_comb begin
    sys_haz = id_sys && sys_src_busy;
    lu_haz  = (id_use_a && ld_a) || (id_use_b && ld_b);
    stall   = id_valid && !flush && (lu_haz || sys_haz || state == ST_SYS_WAIT);
    bubble  = stall || flush;
    fwd_a   = (id_valid && id_use_a) ? sel_a : '0;
    fwd_b   = (id_valid && id_use_b) ? sel_b : '0;
    issue   = id_valid && !stall && !flush;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (id_valid && sys_haz && !flush) state_nxt = ST_SYS_WAIT;
      ST_SYS_WAIT: if (!sys_haz || flush)             state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
      sb_v  <= '0;
      sb_ld <= '0;
      for (int i = 0; i < DEPTH; i++) sb_des[i] <= '0;
    end else begin
      state <= state_nxt;
      sb_v  <= {sb_v[DEPTH-2:0], issue};
      sb_ld <= {sb_ld[DEPTH-2:0], issue && id_load};
      for (int i = DEPTH-1; i > 0; i--) sb_des[i] <= sb_des[i-1];
      sb_des[0] <= issue ? id_des : '0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_q, sys_q, flush_q;
  logic             lu_ev;

  assign lu_ev = id_valid && !flush && lu_haz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lu_q    <= '0;
      sys_q   <= '0;
      flush_q <= '0;
    end else begin
      if (lu_ev && lu_q != '1)                  lu_q    <= lu_q + CNT_W'(1);
      if (state == ST_SYS_WAIT && sys_q != '1)  sys_q   <= sys_q + CNT_W'(1);
      if (flush && flush_q != '1)               flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign lu_cnt    = lu_q;
  assign sys_cnt   = sys_q;
  assign flush_cnt = flush_q;
`else
  assign lu_cnt    = '0;
  assign sys_cnt   = '0;
  assign flush_cnt = '0;
`endif

endmodule
